// File: rtl/alu_issue_wb.sv
// alu_issue_wb: execute-stage issue/writeback controller wrapped around an external 8-bit ALU.
// One instruction in flight: IDLE accepts, EXEC lets the ALU settle, WB holds the result until taken.
module alu_issue_wb #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_sign,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_rd,
  output logic [3:0]        res_flags,
  output logic              res_err,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1110: op_is_legal = 1'b1;
      default:                                              op_is_legal = 1'b0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic                illegal_q, illegal_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [ADDR_W-1:0]   res_rd_q, res_rd_d;
  logic [3:0]          res_flags_q, res_flags_d;
  logic                res_err_q, res_err_d;
  logic [3:0]          alu_flags_s;

  assign alu_flags_s = {alu_carry, alu_zero, alu_overflow, alu_sign};

  // Next-state and datapath updates for the issue/exec/writeback sequence.
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    illegal_d   = illegal_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    res_flags_d = res_flags_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          alu_a_d   = regs_q[in_rs1];
          alu_b_d   = in_use_imm ? in_imm : regs_q[in_rs2];
          alu_op_d  = in_op;
          rd_d      = in_rd;
          illegal_d = ~op_is_legal(in_op);
          state_d   = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        // Illegal ops report the untouched status register and never write back.
        if (!illegal_q) begin
          regs_d[rd_q] = alu_result;
          flags_d      = alu_flags_s;
          res_data_d   = alu_result;
          res_flags_d  = alu_flags_s;
          res_err_d    = 1'b0;
        end else begin
          res_data_d  = {DATA_W{1'b0}};
          res_flags_d = flags_q;
          res_err_d   = 1'b1;
        end
        res_rd_d    = rd_q;
        res_valid_d = 1'b1;
        state_d     = S_WB;
      end
      S_WB: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      flags_q     <= 4'b0000;
      alu_a_q     <= {DATA_W{1'b0}};
      alu_b_q     <= {DATA_W{1'b0}};
      alu_op_q    <= 4'b0000;
      rd_q        <= {ADDR_W{1'b0}};
      illegal_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {DATA_W{1'b0}};
      res_rd_q    <= {ADDR_W{1'b0}};
      res_flags_q <= 4'b0000;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_flags_q <= res_flags_d;
      res_err_q   <= res_err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_flags = res_flags_q;
  assign res_err   = res_err_q;
  assign flags     = flags_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed bench with a behavioural ALU stub, a transaction-level
// regfile/flags model and a per-cycle compare process.
module tb_alu_issue_wb;
  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_OR = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b1101, OP_DIV = 4'b1110, OP_BAD = 4'b0111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_ready;
  logic [3:0]        in_op = 4'b0000;
  logic [ADDR_W-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic              in_use_imm = 1'b0;
  logic [DATA_W-1:0] in_imm = '0;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]        alu_op;
  logic              alu_carry, alu_zero, alu_overflow, alu_sign;
  logic              res_valid, res_ready = 1'b1, res_err;
  logic [DATA_W-1:0] res_data, dbg_data;
  logic [ADDR_W-1:0] res_rd, dbg_addr = '0;
  logic [3:0]        res_flags, flags;

  alu_issue_wb #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_sign(alu_sign),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .res_flags(res_flags), .res_err(res_err), .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Returns {legal, C, Z, V, S, result[7:0]}.
  function automatic logic [12:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s9; logic [15:0] p; logic [7:0] r; logic c, v, ok;
    c = 1'b0; v = 1'b0; ok = 1'b1; r = 8'h00;
    case (op)
      OP_ADD: begin s9 = {1'b0, a} + {1'b0, b}; r = s9[7:0]; c = s9[8];
                    v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'b0010: r = a & b;
      OP_OR:   r = a | b;
      OP_MUL: begin p = 16'(a) * 16'(b); r = p[7:0]; c = |p[15:8]; end
      OP_DIV: begin if (b == 8'h00) begin r = 8'hFF; c = 1'b1; end else r = a / b; end
      default: ok = 1'b0;
    endcase
    return {ok, c, ok && (r == 8'h00), v, r[7], r};
  endfunction

  logic [12:0] alu_bus;
  always_comb alu_bus = alu_model(alu_op, alu_a, alu_b);
  assign alu_result   = alu_bus[7:0];
  assign alu_carry    = alu_bus[11];
  assign alu_zero     = alu_bus[10];
  assign alu_overflow = alu_bus[9];
  assign alu_sign     = alu_bus[8];

  typedef struct { logic [7:0] data; logic [2:0] rd; logic [3:0] fl; logic err; } exp_t;
  exp_t        expq[$];
  logic [7:0]  mregs [NREGS];
  logic [3:0]  mflags;
  exp_t        last;
  int          n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_res_valid", 32'(res_valid), 32'd0);
        end else begin
          chk("res_data", 32'(res_data), 32'(expq[0].data));
          chk("res_rd", 32'(res_rd), 32'(expq[0].rd));
          chk("res_flags", 32'(res_flags), 32'(expq[0].fl));
          chk("res_err", 32'(res_err), 32'(expq[0].err));
          if (res_ready) begin
            last = expq.pop_front();
            if (!last.err) begin
              mregs[last.rd] = last.data;
              mflags = last.fl;
            end
          end
        end
      end else if (in_ready && expq.size() == 0) begin
        chk("dbg_data", 32'(dbg_data), 32'(mregs[dbg_addr]));
        chk("flags", 32'(flags), 32'(mflags));
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    do begin @(posedge clk); #1; guard++; end while (!in_ready && guard < 50);
    chk("wait_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm);
    exp_t e; logic [12:0] r; logic [7:0] b;
    wait_idle();
    b = use_imm ? imm : mregs[rs2];
    r = alu_model(op, mregs[rs1], b);
    e.rd = rd;
    if (r[12]) begin e.data = r[7:0]; e.fl = r[11:8]; e.err = 1'b0; end
    else begin e.data = 8'h00; e.fl = mflags; e.err = 1'b1; end
    expq.push_back(e);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_use_imm = use_imm; in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_res_valid", 32'(res_valid), 32'd0);
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("latency_res_valid", 32'(res_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    mflags = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_bus", 32'({res_data, res_rd, res_flags, res_err}), 32'd0);
    chk("rst_alu_bus", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = 3'(i); #1;
      chk("rst_regfile", 32'(dbg_data), 32'd0);
    end

    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h0F);
    issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h01);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
    wait_idle();
    dbg_addr = 3'd3; #1;
    chk("r3_lit", 32'(dbg_data), 32'h10);
    chk("r3_flags_lit", 32'(flags), 32'h0);
    chk("r3_rd_lit", 32'(last.rd), 32'd3);

    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F);
    issue(OP_ADD, 3'd4, 3'd1, 3'd0, 1'b1, 8'h01);
    wait_idle();
    dbg_addr = 3'd4; #1;
    chk("r4_lit", 32'(dbg_data), 32'h80);
    chk("ovf_flags_lit", 32'(flags), 32'(4'b0011));

    issue(OP_SUB, 3'd5, 3'd0, 3'd0, 1'b1, 8'h01);
    wait_idle();
    chk("sub_data_lit", 32'(last.data), 32'hFF);
    chk("sub_flags_lit", 32'(flags), 32'(4'b1001));

    issue(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 8'h08);
    issue(OP_DIV, 3'd6, 3'd7, 3'd0, 1'b1, 8'h00);
    wait_idle();
    chk("div0_data_lit", 32'(last.data), 32'hFF);
    chk("div0_flags_lit", 32'(flags), 32'(4'b1001));
    issue(OP_MUL, 3'd5, 3'd7, 3'd0, 1'b1, 8'h02);
    wait_idle();
    chk("mul_data_lit", 32'(last.data), 32'h10);
    chk("mul_flags_lit", 32'(flags), 32'h0);

    issue(OP_BAD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h55);
    wait_idle();
    dbg_addr = 3'd2; #1;
    chk("illegal_err_lit", 32'(last.err), 32'd1);
    chk("illegal_data_lit", 32'(last.data), 32'h0);
    chk("illegal_r2_lit", 32'(dbg_data), 32'h01);
    chk("illegal_flags_lit", 32'(flags), 32'h0);

    // Backpressure: hold the result, offer a second instruction meanwhile.
    res_ready = 1'b0;
    issue(OP_ADD, 3'd3, 3'd2, 3'd2, 1'b0, 8'h00);
    in_op = OP_OR; in_rd = 3'd4; in_rs1 = 3'd3; in_use_imm = 1'b1; in_imm = 8'h40;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_data_lit", 32'(res_data), 32'h02);
    end
    res_ready = 1'b1;
    issue(OP_OR, 3'd4, 3'd3, 3'd0, 1'b1, 8'h40);
    wait_idle();
    dbg_addr = 3'd4; #1;
    chk("second_after_hold_lit", 32'(dbg_data), 32'h42);

    // Reset during EXEC drops the in-flight write.
    wait_idle();
    in_op = OP_ADD; in_rd = 3'd7; in_rs1 = 3'd0; in_use_imm = 1'b1; in_imm = 8'h33;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expq.delete();
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    mflags = 4'b0000;
    dbg_addr = 3'd7; #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_r7_lit", 32'(dbg_data), 32'h0);
    chk("midrst_flags_lit", 32'(flags), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 32'(res_valid), 32'd0);
    end

    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    wait_idle();
    dbg_addr = 3'd1; #1;
    chk("post_rst_r1_lit", 32'(dbg_data), 32'h05);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Execute-stage controller sitting directly around alu_8bit: upstream it accepts decoded instructions over a valid/ready handshake.
- Reads operands from an internal 8x8 register file, drives the ALU's A/B/opcode, then captures result and {carry,zero,overflow,sign} on writeback.
- Presents each completed result downstream on a second valid/ready handshake.
- Multi-cycle, one instruction in flight.

Parameters:
DATA_W, 8, datapath width; must equal the ALU width
NREGS, 8, register-file depth
ADDR_W, 3, register address width, equals log2(NREGS)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  instruction offered
in_ready  out  1  block can accept an instruction
in_op  in  4  ALU opcode
in_rd  in  ADDR_W  destination register
in_rs1  in  ADDR_W  source for A
in_rs2  in  ADDR_W  source for B when in_use_imm=0
in_use_imm  in  1  B taken from in_imm instead of in_rs2
in_imm  in  DATA_W  immediate
alu_a  out  DATA_W  to ALU A
alu_b  out  DATA_W  to ALU B
alu_op  out  4  to ALU opcode
alu_result  in  DATA_W  from ALU
alu_carry, alu_zero, alu_overflow, alu_sign  in  1 each  from ALU
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  DATA_W  written value
res_rd  out  ADDR_W  destination of res_data
res_flags  out  4  {carry,zero,overflow,sign}
res_err  out  1  illegal opcode; no write performed
flags  out  4  architectural status register {C,Z,V,S}
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  combinational regfile[dbg_addr]

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All regfile entries, flags, alu_a, alu_b, alu_op, res_data, res_rd, res_flags and res_err are set to 0.
  - res_valid=0. in_ready=1 from the first cycle after reset.
  - Reset mid-operation drops the in-flight instruction: no regfile write and no result is produced.
- Legal opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 1101 MUL, 1110 DIV. All others are illegal.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register alu_a<=reg[in_rs1] and alu_b<=(in_use_imm ? in_imm : reg[in_rs2]).
  - Register alu_op<=in_op. Latch rd and the legal/illegal flag.
  - Next state EXEC.
- State EXEC (exactly 1 cycle):
  - in_ready=0. alu_* outputs are stable and the ALU settles combinationally.
  - At the edge ending EXEC, for a legal opcode:
    - reg[rd]<=alu_result and flags<=ALU flags.
    - res_data<=alu_result, res_flags<=ALU flags, res_err<=0.
  - At the edge ending EXEC, for an illegal opcode:
    - Regfile and flags are unchanged.
    - res_data<=0, res_flags<=flags, res_err<=1.
  - res_rd<=rd and res_valid<=1. Next state WB.
- State WB:
  - in_ready=0. res_valid=1.
  - res_* outputs are held stable until res_ready=1.
  - When res_valid&res_ready, the next state is IDLE and res_valid drops on that edge.
- Latency and throughput:
  - Accept edge to res_valid high is 2 edges.
  - Minimum issue interval is 3 cycles with res_ready tied high.
- Hazards:
  - None. The write lands before the next accept, so a following instruction reading rd sees the new value.
- dbg_data is a combinational read of the regfile and reflects a write from the cycle after it.
- in_valid outside IDLE is ignored; the upstream source must hold the instruction.
- alu_a, alu_b and alu_op hold their last values outside EXEC.
- Division by zero: the result and flags are whatever the ALU reports (0xFF, C=1, S=1), written normally.

Test Plan:
- Reset, then ADD r1,r0,imm=0x0F; ADD r2,r0,imm=0x01; ADD r3,r1,r2 -> r3=0x10, flags=0000, res_rd=3, res_valid exactly 2 edges after accept.
- Load r1=0x7F; ADD r4,r1,imm=0x01 -> res_data=0x80, flags C=0 Z=0 V=1 S=1 (0011); dbg_addr=4 gives 0x80.
- SUB r5,r0,imm=0x01 -> 0xFF, C=1 S=1. Then DIV r6,(r=0x08),imm=0 -> 0xFF, C=1 S=1. Then MUL 0x08*0x02 -> 0x10.
- Illegal op 0111 to rd=2 (r2=0x01) -> res_err=1, res_data=0, r2 still 0x01, flags unchanged.
- Hold res_ready=0 for 5 cycles in WB -> res_* stable, in_ready=0, a second in_valid is not accepted. Release -> back to IDLE, then the second instruction is accepted.
- Assert rst_n=0 during EXEC of ADD r7 -> next cycle IDLE, res_valid=0, r7=0, flags=0.
